systolic_matmul_engine: RTL

// Parametrised output-stationary systolic matrix-multiply engine: C[ROWS][COLS] = A[ROWS][K] x B[K][COLS].

---
 rtl/systolic_matmul_engine.sv | 216 +++++++++++++++++++++
 1 files changed

// File: rtl/systolic_matmul_engine.sv
// Output-stationary systolic matrix-multiply engine: C = A x B.
// Operands arrive one k-step per beat (A column, B row). They are skewed on
// chip and streamed through a ROWS x COLS grid of multiply-accumulate cells.
// Results then drain one row per handshake.
// Handshakes: a transfer happens on a rising clk edge where valid && ready are
// both high. The source holds its payload stable while valid && !ready. Ready
// never depends combinationally on valid.
module systolic_matmul_engine #(
  parameter int ROWS = 4,
  parameter int COLS = 4,
  parameter int DW   = 8,
  parameter int AW   = 32,
  parameter int KW   = 8,
  localparam int RW  = (ROWS > 1) ? $clog2(ROWS) : 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [KW-1:0]        k_len,
  input  logic                 signed_mode,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [ROWS*DW-1:0]   a_col,
  input  logic [COLS*DW-1:0]   b_row,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [RW-1:0]        out_row,
  output logic [COLS*AW-1:0]   out_data,
  output logic                 busy,
  output logic                 done,
  output logic [1:0]           dbg_state
);

  typedef enum logic [1:0] {IDLE = 2'd0, LOAD = 2'd1, FLUSH = 2'd2, DRAIN = 2'd3} state_t;

  localparam int FLUSH_N = ROWS + COLS - 2;
  localparam int FCW     = $clog2(ROWS + COLS) + 1;

  state_t            state, state_nxt;
  logic              adv;        // whole array (skew + PEs) steps once
  logic              clr;        // job start: wipe accumulators, latch config
  logic [KW-1:0]     k_lat;
  logic              sm_lat;
  logic [KW-1:0]     beat_cnt;
  logic [FCW-1:0]    flush_cnt;
  logic [RW-1:0]     row_cnt;
  logic              last_row;

  logic [DW-1:0] a_edge [ROWS];  // skewed A entering column 0
  logic [DW-1:0] b_edge [COLS];  // skewed B entering row 0
  logic [DW-1:0] pe_a   [ROWS][COLS];
  logic [DW-1:0] pe_b   [ROWS][COLS];
  logic [DW-1:0] a_pipe [ROWS][COLS];
  logic [DW-1:0] b_pipe [ROWS][COLS];
  logic [AW-1:0] acc    [ROWS][COLS];

  assign last_row  = (row_cnt == RW'(ROWS - 1));
  assign busy      = (state != IDLE);
  assign dbg_state = state;
  assign out_row   = row_cnt;

  // Extended a*b term, sign- or zero-extended according to the latched mode
  function automatic logic [AW-1:0] mac_term(input logic [DW-1:0] a, input logic [DW-1:0] b,
                                             input logic sm);
    logic signed [2*DW-1:0] ps;
    logic [2*DW-1:0]        pu;
    ps = $signed(a) * $signed(b);
    pu = a * b;
    return sm ? AW'(ps) : AW'(pu);
  endfunction

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state and control decode
  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    adv       = 1'b0;
    clr       = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          clr       = 1'b1;
          state_nxt = (k_len != '0) ? LOAD : DRAIN;
        end
      end
      LOAD: begin
        in_ready = 1'b1;
        if (in_valid) begin
          adv = 1'b1;
          if (beat_cnt == k_lat - KW'(1)) state_nxt = (FLUSH_N != 0) ? FLUSH : DRAIN;
        end
      end
      FLUSH: begin
        adv = 1'b1;
        if (flush_cnt == FCW'(FLUSH_N - 1)) state_nxt = DRAIN;
      end
      DRAIN: begin
        out_valid = 1'b1;
        if (out_ready && last_row) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Job configuration, beat/flush/row counters and the done pulse
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      k_lat     <= '0;
      sm_lat    <= 1'b0;
      beat_cnt  <= '0;
      flush_cnt <= '0;
      row_cnt   <= '0;
      done      <= 1'b0;
    end else begin
      done <= (state == DRAIN) && out_ready && last_row;
      if (clr) begin
        k_lat     <= k_len;
        sm_lat    <= signed_mode;
        beat_cnt  <= '0;
        flush_cnt <= '0;
        row_cnt   <= '0;
      end else begin
        if (state == LOAD && adv) beat_cnt <= beat_cnt + KW'(1);
        if (state == FLUSH)       flush_cnt <= flush_cnt + FCW'(1);
        if (state == DRAIN && out_ready) row_cnt <= last_row ? '0 : row_cnt + RW'(1);
      end
    end
  end

  // Input skew: lane i of A (and of B) is delayed i advance-steps; zeros follow the last beat
  for (genvar gi = 0; gi < ROWS; gi++) begin : g_askew
    logic [DW-1:0] a_src;
    assign a_src = (state == LOAD) ? a_col[gi*DW +: DW] : '0;
    if (gi == 0) begin : g_direct
      assign a_edge[gi] = a_src;
    end else begin : g_dly
      logic [DW-1:0] sr [gi];
      // Shift chain advancing only with the array
      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          for (int d = 0; d < gi; d++) sr[d] <= '0;
        end else if (adv) begin
          sr[0] <= a_src;
          for (int d = 1; d < gi; d++) sr[d] <= sr[d-1];
        end
      end
      assign a_edge[gi] = sr[gi-1];
    end
  end

  for (genvar gj = 0; gj < COLS; gj++) begin : g_bskew
    logic [DW-1:0] b_src;
    assign b_src = (state == LOAD) ? b_row[gj*DW +: DW] : '0;
    if (gj == 0) begin : g_direct
      assign b_edge[gj] = b_src;
    end else begin : g_dly
      logic [DW-1:0] sr [gj];
      // Shift chain advancing only with the array
      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          for (int d = 0; d < gj; d++) sr[d] <= '0;
        end else if (adv) begin
          sr[0] <= b_src;
          for (int d = 1; d < gj; d++) sr[d] <= sr[d-1];
        end
      end
      assign b_edge[gj] = sr[gj-1];
    end
  end

  // PE operand routing: a from the left neighbour, b from the one above
  always_comb begin
    for (int i = 0; i < ROWS; i++) begin
      for (int j = 0; j < COLS; j++) begin
        pe_a[i][j] = (j == 0) ? a_edge[i] : a_pipe[i][(j == 0) ? 0 : j-1];
        pe_b[i][j] = (i == 0) ? b_edge[j] : b_pipe[(i == 0) ? 0 : i-1][j];
      end
    end
  end

  // PE grid: accumulate on each advance and forward operands one step
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < ROWS; i++)
        for (int j = 0; j < COLS; j++) begin
          acc[i][j]    <= '0;
          a_pipe[i][j] <= '0;
          b_pipe[i][j] <= '0;
        end
    end else if (clr) begin
      for (int i = 0; i < ROWS; i++)
        for (int j = 0; j < COLS; j++) acc[i][j] <= '0;
    end else if (adv) begin
      for (int i = 0; i < ROWS; i++)
        for (int j = 0; j < COLS; j++) begin
          acc[i][j]    <= acc[i][j] + mac_term(pe_a[i][j], pe_b[i][j], sm_lat);
          a_pipe[i][j] <= pe_a[i][j];
          b_pipe[i][j] <= pe_b[i][j];
        end
    end
  end

  // Result row mux, driven only while draining
  always_comb begin
    out_data = '0;
    if (state == DRAIN)
      for (int j = 0; j < COLS; j++) out_data[j*AW +: AW] = acc[row_cnt][j];
  end

endmodule
